sync_fifo_ctl: RTL and testbench

Parametrised single-clock FIFO that replaces the ad hoc write/read FIFO port pairs between JPEG pipeline stages (DCT output, quantiser, entropy coder). It adds level reporting, programmable almost-full/almost-empty flags, overflow/underflow pulses and an optional first-word-fall-through (FWFT) read mode. Storage is an inferred RAM of DEPTH words.

---
 rtl/sync_fifo_ctl.sv | 131 +++++++++++++
 tb/tb_sync_fifo_ctl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO with level, threshold flags, error pulses
// and optional first-word-fall-through output.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_en, wr_data        write request and word
//   full, almost_full     no space / level >= AFULL_TH
//   rd_en, rd_data        read request (pop in FWFT mode) and read word
//   empty, almost_empty   nothing readable / level <= AEMPTY_TH
//   level                 words held (FWFT: includes the prefetched head)
//   overflow, underflow   one-cycle pulses for rejected write / read
module sync_fifo_ctl #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter bit FWFT       = 1'b0,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  output logic                          almost_full,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          empty,
  output logic                          almost_empty,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] ONE     = LW'(1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AFULL_TH);
  localparam logic [LW-1:0] AE_L    = LW'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [LW-1:0] wptr;
  logic [LW-1:0] rptr;
  logic [LW-1:0] rptr_inc;
  logic [LW-1:0] level_nxt;

  logic wr_acc;
  logic rd_acc;

  logic [DATA_WIDTH-1:0] rd_nxt;

  assign wr_acc   = wr_en & ~full;
  assign rd_acc   = rd_en & ~empty;
  assign rptr_inc = rptr + ONE;

  // Pointers wrap at 2*DEPTH, so their difference is the exact
  // occupancy 0..DEPTH without a separate counter.
  assign level = wptr - rptr;

  always_comb begin
    level_nxt = level;
    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level + ONE;
      2'b01:   level_nxt = level - ONE;
      default: level_nxt = level;
    endcase
  end

  generate
    if (FWFT) begin : g_fwft
      // rd_data always mirrors the head word. On a pop the next head
      // is fetched, or taken straight from wr_data when that word is
      // being written in the same cycle. On an empty FIFO a write
      // bypasses the RAM. A pop that empties the FIFO leaves the
      // stale word in place.
      always_comb begin
        rd_nxt = rd_data;
        if (rd_acc) begin
          if (level_nxt != '0) begin
            if (wr_acc && level == ONE)
              rd_nxt = wr_data;
            else
              rd_nxt = mem[rptr_inc[AW-1:0]];
          end
        end else if (wr_acc && empty) begin
          rd_nxt = wr_data;
        end
      end
    end else begin : g_std
      always_comb begin
        rd_nxt = rd_data;
        if (rd_acc)
          rd_nxt = mem[rptr[AW-1:0]];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc)
      mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_L == '0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (wr_acc)
        wptr <= wptr + ONE;
      if (rd_acc)
        rptr <= rptr_inc;
      full         <= (level_nxt == DEPTH_L);
      empty        <= (level_nxt == '0);
      almost_full  <= (level_nxt >= AF_L);
      almost_empty <= (level_nxt <= AE_L);
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
      rd_data      <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// tb_sync_fifo_ctl: directed checks of sync_fifo_ctl in standard
// mode (DEPTH=8) and FWFT mode (DEPTH=4).
module tb_sync_fifo_ctl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic       s_wr_en, s_rd_en;
  logic [9:0] s_wr_data, s_rd_data;
  logic       s_full, s_af, s_empty, s_ae, s_ov, s_uf;
  logic [3:0] s_level;

  logic       f_wr_en, f_rd_en;
  logic [9:0] f_wr_data, f_rd_data;
  logic       f_full, f_af, f_empty, f_ae, f_ov, f_uf;
  logic [2:0] f_level;

  sync_fifo_ctl #(
    .DATA_WIDTH(10), .DEPTH(8), .FWFT(1'b0),
    .AFULL_TH(6), .AEMPTY_TH(2)
  ) u_std (
    .clk(clk), .rst_n(rst_n),
    .wr_en(s_wr_en), .wr_data(s_wr_data),
    .full(s_full), .almost_full(s_af),
    .rd_en(s_rd_en), .rd_data(s_rd_data),
    .empty(s_empty), .almost_empty(s_ae),
    .level(s_level),
    .overflow(s_ov), .underflow(s_uf)
  );

  sync_fifo_ctl #(
    .DATA_WIDTH(10), .DEPTH(4), .FWFT(1'b1),
    .AFULL_TH(3), .AEMPTY_TH(1)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n),
    .wr_en(f_wr_en), .wr_data(f_wr_data),
    .full(f_full), .almost_full(f_af),
    .rd_en(f_rd_en), .rd_data(f_rd_data),
    .empty(f_empty), .almost_empty(f_ae),
    .level(f_level),
    .overflow(f_ov), .underflow(f_uf)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] q[$];
  logic [9:0] w;
  int pushed, popped, cyc;
  logic wr, rd, wa, ra;

  initial begin
    rst_n = 1'b0;
    s_wr_en = 0; s_rd_en = 0; s_wr_data = '0;
    f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;
    tick();
    rst_n = 1'b1;

    chk("rst_level", s_level, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_af", s_af, 0);
    chk("rst_rdata", s_rd_data, 0);
    chk("rst_ov", s_ov, 0);
    chk("rst_uf", s_uf, 0);

    // fill 1..8, thresholds on the way up
    for (int i = 1; i <= 8; i++) begin
      s_wr_en = 1; s_wr_data = 10'(i);
      tick();
      chk("fill_level", s_level, i);
      chk("fill_ae", s_ae, (i <= 2));
      chk("fill_af", s_af, (i >= 6));
      chk("fill_full", s_full, (i == 8));
    end
    s_wr_en = 0;

    // write while full
    s_wr_en = 1; s_wr_data = 10'h0AA;
    tick();
    s_wr_en = 0;
    chk("ovf_pulse", s_ov, 1);
    chk("ovf_level", s_level, 8);
    tick();
    chk("ovf_clear", s_ov, 0);
    chk("ovf_level2", s_level, 8);

    // write+read while full
    s_wr_en = 1; s_rd_en = 1; s_wr_data = 10'h0BB;
    tick();
    s_wr_en = 0; s_rd_en = 0;
    chk("fullrw_data", s_rd_data, 10'h001);
    chk("fullrw_ov", s_ov, 1);
    chk("fullrw_level", s_level, 7);
    chk("fullrw_full", s_full, 0);
    tick();
    chk("fullrw_ovclr", s_ov, 0);

    // drain 2..8, thresholds on the way down
    for (int i = 2; i <= 8; i++) begin
      s_rd_en = 1;
      tick();
      chk("drain_data", s_rd_data, i);
      chk("drain_level", s_level, 8 - i);
      chk("drain_af", s_af, ((8 - i) >= 6));
      chk("drain_ae", s_ae, ((8 - i) <= 2));
      chk("drain_empty", s_empty, (i == 8));
    end
    s_rd_en = 0;

    // read while empty
    s_rd_en = 1;
    tick();
    s_rd_en = 0;
    chk("udf_pulse", s_uf, 1);
    chk("udf_rdata", s_rd_data, 10'h008);
    chk("udf_level", s_level, 0);
    tick();
    chk("udf_clear", s_uf, 0);

    // write+read while empty
    s_wr_en = 1; s_rd_en = 1; s_wr_data = 10'h155;
    tick();
    s_wr_en = 0; s_rd_en = 0;
    chk("emprw_level", s_level, 1);
    chk("emprw_uf", s_uf, 1);
    chk("emprw_empty", s_empty, 0);
    chk("emprw_rdata", s_rd_data, 10'h008);
    s_rd_en = 1;
    tick();
    s_rd_en = 0;
    chk("emprw_read", s_rd_data, 10'h155);
    chk("emprw_empty2", s_empty, 1);

    // reset at level 5 with requests pending
    for (int i = 0; i < 5; i++) begin
      s_wr_en = 1; s_wr_data = 10'(16 + i);
      tick();
    end
    s_wr_en = 0;
    chk("mid_level5", s_level, 5);
    rst_n = 0; s_wr_en = 1; s_rd_en = 1; s_wr_data = 10'h111;
    tick();
    rst_n = 1; s_wr_en = 0; s_rd_en = 0;
    chk("mid_level", s_level, 0);
    chk("mid_empty", s_empty, 1);
    chk("mid_rdata", s_rd_data, 0);
    chk("mid_ov", s_ov, 0);
    chk("mid_uf", s_uf, 0);
    s_wr_en = 1; s_wr_data = 10'h3FF;
    tick();
    s_wr_en = 0; s_rd_en = 1;
    tick();
    s_rd_en = 0;
    chk("mid_rt_data", s_rd_data, 10'h3FF);
    chk("mid_rt_empty", s_empty, 1);

    // FWFT: bypass into empty
    chk("fw_rst_empty", f_empty, 1);
    f_wr_en = 1; f_wr_data = 10'h2AA;
    tick();
    f_wr_en = 0;
    chk("fw_byp_empty", f_empty, 0);
    chk("fw_byp_data", f_rd_data, 10'h2AA);
    chk("fw_byp_level", f_level, 1);
    f_rd_en = 1;
    tick();
    f_rd_en = 0;
    chk("fw_pop_empty", f_empty, 1);
    chk("fw_pop_stale", f_rd_data, 10'h2AA);

    // FWFT random stream against a queue model
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 100 && cyc < 3000) begin
      wr = (pushed < 100) && ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 2) != 0);
      w  = 10'($urandom_range(0, 1023));
      wa = wr && (q.size() < 4);
      ra = rd && (q.size() > 0);
      chk("fw_level", f_level, q.size());
      chk("fw_empty", f_empty, (q.size() == 0));
      chk("fw_full", f_full, (q.size() == 4));
      if (ra) begin
        chk("fw_head", f_rd_data, q[0]);
        void'(q.pop_front());
        popped++;
      end
      if (wa) begin
        q.push_back(w);
        pushed++;
      end
      f_wr_en = wr; f_rd_en = rd; f_wr_data = w;
      tick();
      cyc++;
    end
    f_wr_en = 0; f_rd_en = 0;
    if (popped < 100)
      chk("fw_timeout", popped, 100);
    chk("fw_pushed", pushed, 100);
    chk("fw_end_level", f_level, q.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
